// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : debounce_pkg
// Purpose : Shared limits and counter-width helper for the debounce array.
// Rev     : 1.0  initial release
// ============================================================================
package debounce_pkg;

  localparam int DB_MAX_CH     = 32;
  localparam int DB_MAX_STABLE = 255;

  // Counter only ever reaches STABLE_CNT-1; a single bit is kept even for STABLE_CNT=1.
  function automatic int db_cnt_width(input int stable_cnt);
    int w;
    w = $clog2(stable_cnt);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_array_if.sv
`default_nettype none
// ============================================================================
// Module  : debounce_array_if
// Purpose : Sample strobe, raw inputs, sticky clears and filtered outputs.
// Rev     : 1.0  initial release
// ============================================================================
interface debounce_array_if #(
  parameter int CH = 8
);

  logic          ck_enable;
  logic [CH-1:0] in;
  logic [CH-1:0] clr_chg;
  logic [CH-1:0] out;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] chg_sticky;

  modport master (
    output ck_enable, in, clr_chg,
    input  out, rise, fall, chg_sticky
  );

  modport slave (
    input  ck_enable, in, clr_chg,
    output out, rise, fall, chg_sticky
  );

endinterface
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
// Module  : debounce_ch
// Purpose : One debounce channel: 2-flop synchroniser, run-length qualifier,
//           filtered level, edge pulses and sticky change flag.
// Rev     : 1.0  initial release
// ============================================================================
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter bit INIT_VAL   = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic ck_enable_i,
  input  wire logic in_i,
  input  wire logic clr_chg_i,
  output logic      out_o,
  output logic      rise_o,
  output logic      fall_o,
  output logic      chg_sticky_o
);

  localparam int             c_cnt_w    = db_cnt_width(STABLE_CNT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CNT - 1);

  logic               sync1_q, sync2_q;
  logic               out_q, out_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               sticky_q, sticky_d;

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (ck_enable_i) begin
      if (sync2_q == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_cnt_last) begin
        out_d  = sync2_q;
        cnt_d  = '0;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + c_cnt_w'(1);
      end
    end
    // A new edge outranks a clear arriving on the same clock.
    if (rise_d | fall_d) begin
      sticky_d = 1'b1;
    end else if (clr_chg_i) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= INIT_VAL;
      sync2_q  <= INIT_VAL;
      out_q    <= INIT_VAL;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync1_q  <= in_i;
      sync2_q  <= sync1_q;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_o        = out_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign chg_sticky_o = sticky_q;

endmodule
`default_nettype wire

// File: rtl/debounce_array.sv
`default_nettype none
// ============================================================================
// Module  : debounce_array
// Purpose : CH independent debounce channels sharing one sample strobe.
// Rev     : 1.0  initial release
// ============================================================================
module debounce_array
  import debounce_pkg::*;
#(
  parameter int          CH         = 8,
  parameter int          STABLE_CNT = 4,
  parameter logic [CH-1:0] INIT_VAL = '0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  debounce_array_if.slave  bus
);

  logic [CH-1:0] w_out;
  logic [CH-1:0] w_rise;
  logic [CH-1:0] w_fall;
  logic [CH-1:0] w_sticky;

  if (CH < 1 || CH > DB_MAX_CH || STABLE_CNT < 1 || STABLE_CNT > DB_MAX_STABLE) begin : g_bad_param
    $error("debounce_array: illegal CH=%0d or STABLE_CNT=%0d", CH, STABLE_CNT);
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .INIT_VAL   (INIT_VAL[g])
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .ck_enable_i  (bus.ck_enable),
      .in_i         (bus.in[g]),
      .clr_chg_i    (bus.clr_chg[g]),
      .out_o        (w_out[g]),
      .rise_o       (w_rise[g]),
      .fall_o       (w_fall[g]),
      .chg_sticky_o (w_sticky[g])
    );
  end

  assign bus.out        = w_out;
  assign bus.rise       = w_rise;
  assign bus.fall       = w_fall;
  assign bus.chg_sticky = w_sticky;

endmodule
`default_nettype wire

// File: tb/tb_debounce_array.sv
`default_nettype none
// ============================================================================
// Module  : tb_debounce_array
// Purpose : Directed vectors for three debounce_array configurations.
// Rev     : 1.0  initial release
// ============================================================================
module tb_debounce_array;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  debounce_array_if #(.CH(4)) ifa ();
  debounce_array_if #(.CH(4)) ifb ();
  debounce_array_if #(.CH(4)) ifc ();

  // A: slow strobe, 4 samples. B: fast mode, 1 sample. C: non-zero reset value.
  debounce_array #(.CH(4), .STABLE_CNT(4), .INIT_VAL(4'b0000)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  debounce_array #(.CH(4), .STABLE_CNT(1), .INIT_VAL(4'b0000)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  debounce_array #(.CH(4), .STABLE_CNT(4), .INIT_VAL(4'b1010)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         reps;
    logic       en;
    logic [3:0] din;
    logic [3:0] clr;
    logic [3:0] e_out;
    logic [3:0] e_rise;
    logic [3:0] e_fall;
    logic [3:0] e_st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int reps, logic en, logic [3:0] din, logic [3:0] clr,
                              logic [3:0] eo, logic [3:0] er, logic [3:0] ef, logic [3:0] es);
    vec_t v;
    v.reps = reps; v.en = en; v.din = din; v.clr = clr;
    v.e_out = eo; v.e_rise = er; v.e_fall = ef; v.e_st = es;
    return v;
  endfunction

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [3:0] ao, logic [3:0] ar, logic [3:0] af, logic [3:0] as,
                         logic [3:0] eo, logic [3:0] er, logic [3:0] ef, logic [3:0] es);
    chk({nm, ".out"},  ao, eo);
    chk({nm, ".rise"}, ar, er);
    chk({nm, ".fall"}, af, ef);
    chk({nm, ".chg"},  as, es);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    ifa.ck_enable = 1'b0; ifa.in = 4'b0000; ifa.clr_chg = 4'b0000;
    ifb.ck_enable = 1'b1; ifb.in = 4'b0000; ifb.clr_chg = 4'b0000;
    ifc.ck_enable = 1'b1; ifc.in = 4'b1010; ifc.clr_chg = 4'b0000;

    // Reset state of all three instances
    repeat (3) tick();
    chk_all("rst_a", ifa.out, ifa.rise, ifa.fall, ifa.chg_sticky, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk_all("rst_b", ifb.out, ifb.rise, ifb.fall, ifb.chg_sticky, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk_all("rst_c", ifc.out, ifc.rise, ifc.fall, ifc.chg_sticky, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;

    // INIT_VAL=1010 with matching input: nothing moves after release
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all($sformatf("init_c%0d", i), ifc.out, ifc.rise, ifc.fall, ifc.chg_sticky,
              4'b1010, 4'b0000, 4'b0000, 4'b0000);
    end

    // Reset mid-qualification: ch1 settles high, then ch0 gets 2 of 4 samples
    ifa.ck_enable = 1'b1;
    ifa.in = 4'b0010;
    repeat (6) tick();
    chk_all("r4_ch1_up", ifa.out, ifa.rise, ifa.fall, ifa.chg_sticky, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    ifa.in = 4'b0011;
    repeat (4) tick();
    chk_all("r4_pre", ifa.out, ifa.rise, ifa.fall, ifa.chg_sticky, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    #2 rst = 1'b0;
    #1;
    chk_all("r4_async", ifa.out, ifa.rise, ifa.fall, ifa.chg_sticky, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("r4_async_c.out", ifc.out, 4'b1010);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all($sformatf("r4_rel%0d", i), ifa.out, ifa.rise, ifa.fall, ifa.chg_sticky,
              4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    tick();
    chk_all("r4_rel6", ifa.out, ifa.rise, ifa.fall, ifa.chg_sticky, 4'b0011, 4'b0011, 4'b0000, 4'b0011);
    tick();
    chk_all("r4_rel7", ifa.out, ifa.rise, ifa.fall, ifa.chg_sticky, 4'b0011, 4'b0000, 4'b0000, 4'b0011);

    // Clean restart for the table
    rst = 1'b0;
    ifa.ck_enable = 1'b0;
    ifa.in = 4'b0000;
    tick();
    tick();
    rst = 1'b1;

    // Slow strobe every 4th clk, ch0 raised and held
    tbl.push_back(mk(3, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(3, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(3, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(3, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
    // Bounce on ch1: 1,1,1,0 then steady 1
    tbl.push_back(mk(3, 1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
    tbl.push_back(mk(5, 1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 1'b1, 4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0011));
    tbl.push_back(mk(2, 1'b1, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011));
    // ch0 falls with a coincident clear, then clears on their own
    tbl.push_back(mk(5, 1'b1, 4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011));
    tbl.push_back(mk(1, 1'b1, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0011));
    tbl.push_back(mk(1, 1'b1, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0010));
    tbl.push_back(mk(1, 1'b1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000));

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        ifa.ck_enable = tbl[r].en;
        ifa.in        = tbl[r].din;
        ifa.clr_chg   = tbl[r].clr;
        tick();
        chk_all($sformatf("vec%0d_%0d", r, k), ifa.out, ifa.rise, ifa.fall, ifa.chg_sticky,
                tbl[r].e_out, tbl[r].e_rise, tbl[r].e_fall, tbl[r].e_st);
      end
    end
    ifa.clr_chg = 4'b0000;

    // Fast mode, STABLE_CNT=1: 1-clk pulse on ch2
    ifb.in = 4'b0100;
    tick();
    ifb.in = 4'b0000;
    chk_all("fast1", ifb.out, ifb.rise, ifb.fall, ifb.chg_sticky, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk_all("fast2", ifb.out, ifb.rise, ifb.fall, ifb.chg_sticky, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk_all("fast3", ifb.out, ifb.rise, ifb.fall, ifb.chg_sticky, 4'b0100, 4'b0100, 4'b0000, 4'b0100);
    tick();
    chk_all("fast4", ifb.out, ifb.rise, ifb.fall, ifb.chg_sticky, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    tick();
    chk_all("fast5", ifb.out, ifb.rise, ifb.fall, ifb.chg_sticky, 4'b0000, 4'b0000, 4'b0000, 4'b0100);

    chk_all("final_c", ifc.out, ifc.rise, ifc.fall, ifc.chg_sticky, 4'b1010, 4'b0000, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debounce_array.md
Name: debounce_array

Overview:
- Multi-channel, parametrised successor to the single-bit 2-sample debouncer.
- Each channel synchronises an asynchronous input and qualifies it over a programmable number of consecutive clock-enabled samples.
- Each channel produces a filtered level plus registered rise/fall pulses.
- A sticky per-channel change flag with software clear serves status registers feeding the I2C/sideband logic.

Parameters:
- CH, 8, number of independent channels (1..32).
- STABLE_CNT, 4, consecutive enabled samples that must differ from the current output before it flips (1..255).
- INIT_VAL, {CH{1'b0}}, per-channel reset value of the output level and of the synchroniser flops.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- ck_enable  input  1  sample strobe. Tie to 1'b1 for fast mode.
- in  input  CH  raw asynchronous inputs.
- clr_chg  input  CH  per-channel clear of chg_sticky (single-clk pulse).
- out  output  CH  debounced level.
- rise  output  CH  one-clk pulse when out goes 0->1.
- fall  output  CH  one-clk pulse when out goes 1->0.
- chg_sticky  output  CH  latched "out changed since last clear".

Behaviour:
- Reset (rst low, asynchronous, immediate, including mid-qualification):
  - out=INIT_VAL; sync flops=INIT_VAL; counters=0; rise=fall=0; chg_sticky=0.
  - No edge pulse is generated on reset release.
- Synchroniser: 2-flop per channel, clocked every clk and not gated by ck_enable; sync = second flop.
- Per channel, evaluated only on clk edges with ck_enable=1:
  - sync==out: counter cleared to 0.
  - sync!=out and counter<STABLE_CNT-1: counter+1.
  - sync!=out and counter==STABLE_CNT-1: out<=sync, counter<=0, and the matching rise/fall is registered high on the same edge.
- Counter width is $clog2(STABLE_CNT) with a minimum of 1. The counter never exceeds STABLE_CNT-1.
- Any sample agreeing with out restarts qualification; there is no partial credit.
- STABLE_CNT=1: out follows sync on every enabled sample. Fast mode then gives 3-clk latency from in.
- ck_enable=0: counters and out hold, and rise/fall are 0. Held counts survive gaps between strobes.
- Latency from a clean in transition: 2 clk (sync) + STABLE_CNT enabled samples.
- rise/fall:
  - High for exactly one clk, in the cycle out shows its new value.
  - Never both high on one channel.
  - Deasserted next clk, even if ck_enable stays high.
- chg_sticky[i]:
  - Set when rise[i]|fall[i] is being registered.
  - Cleared by clr_chg[i].
  - Set and clear in the same clk: set wins.
- Channels are fully independent; simultaneous events on different channels are all honoured the same cycle.
- Illegal parameters (CH<1, STABLE_CNT<1 or >255) are stopped at elaboration by a generate-time check.

Decomposition:
- Package debounce_pkg:
  - Constants DB_MAX_CH=32 and DB_MAX_STABLE=255.
  - A cnt-width function (clog2 with min 1).
- Sub-module debounce_ch (single channel: synchroniser, counter, out/rise/fall/sticky).
  - Instantiated CH times via generate in debounce_array.
  - Parameters STABLE_CNT and INIT_VAL bit.

Test Plan:
- Test 1, CH=4, STABLE_CNT=4, ck_enable every 4th clk:
  - Stimulus: raise in[0] after reset and hold.
  - Required: out[0] rises at the 4th enabled sample after sync; rise[0] is a 1-clk pulse; chg_sticky[0]=1; channels 1..3 stay 0.
- Test 2, bounce rejection:
  - Stimulus: in[1] toggles 1,1,1,0 across enabled samples, then steady 1.
  - Required: no change until 4 consecutive 1 samples; exactly one rise[1].
- Test 3, fast mode (ck_enable=1, STABLE_CNT=1):
  - Stimulus: 1-clk in[2] pulse.
  - Required: out[2] high 3 clk after in (one clk wide); rise then fall on consecutive cycles.
- Test 4, reset mid-operation:
  - Stimulus: assert rst after 2 of 4 qualifying samples.
  - Required: out=INIT_VAL immediately; counter restarts; no pulse on release with in unchanged and INIT_VAL=0.
- Test 5, INIT_VAL=4'b1010 with in=4'b1010 held through reset:
  - Required: no rise/fall after release; out=4'b1010.
- Test 6, clr_chg coincident with a new fall on the same channel:
  - Required: chg_sticky stays 1.
  - Follow-up: clr_chg alone clears it to 0 next clk.
